// File: rtl/m_store_unit_if.sv
// m_store_unit_if: write-side request/ack bus between the M-stage store unit and the bridge
interface m_store_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        ack;
    modport master(output req, addr, wdata, be, input ack);
    modport slave(input req, addr, wdata, be, output ack);
endinterface

// File: rtl/m_store_unit.sv
// m_store_unit: M-stage store path with AdES detection, lane formatting and a single-write bus handshake
module m_store_unit #(
    parameter logic [31:0] DM_END  = 32'h0000_2FFF,
    parameter logic [31:0] T1_BASE = 32'h0000_7F00,
    parameter logic [31:0] T2_BASE = 32'h0000_7F10
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           st_valid,
    input  logic [1:0]     st_sel,
    input  logic [31:0]    st_addr,
    input  logic [31:0]    st_wdata,
    input  logic           st_ov,
    input  logic           st_flush,
    output logic           st_exades,
    output logic           st_stall,
    output logic           st_done,
    m_store_unit_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state, state_nx;
    logic [31:0] off1, off2, data_nx;
    logic [3:0]  be_nx;
    logic        is_st, in_t1, in_t2, timer, cnt_reg, fault, accept;

    assign off1    = st_addr - T1_BASE;
    assign off2    = st_addr - T2_BASE;
    assign in_t1   = st_addr >= T1_BASE && off1 < 32'd12;
    assign in_t2   = st_addr >= T2_BASE && off2 < 32'd12;
    assign timer   = in_t1 || in_t2;
    assign cnt_reg = (in_t1 && off1[3:2] == 2'd2) || (in_t2 && off2[3:2] == 2'd2);
    assign is_st   = st_valid && st_sel != 2'd3;
    assign fault   = st_ov
                   || (st_sel == 2'd0 && st_addr[1:0] != 2'd0)
                   || (st_sel == 2'd1 && st_addr[0])
                   || !(st_addr <= DM_END || timer)
                   || (timer && st_sel != 2'd0)
                   || cnt_reg;
    assign accept  = state == IDLE && is_st && !fault && !st_flush;
    assign be_nx   = st_sel == 2'd0 ? 4'hF
                   : st_sel == 2'd1 ? (st_addr[1] ? 4'hC : 4'h3)
                   : 4'b0001 << st_addr[1:0];
    assign data_nx = st_sel == 2'd0 ? st_wdata
                   : st_sel == 2'd1 ? {2{st_wdata[15:0]}}
                   : {4{st_wdata[7:0]}};

    // state register; reset abandons any pending write
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= IDLE;
        else        state <= state_nx;

    // an accepted store occupies the bus until the bridge acks it
    always_comb
        state_nx = state == IDLE ? (accept ? BUSY : IDLE) : (bus.ack ? IDLE : BUSY);

    // request, exception and stall; ack only matters while BUSY
    always_comb begin
        bus.req   = state == BUSY;
        st_exades = is_st && state == IDLE && fault;
        st_stall  = accept || (state == BUSY && !bus.ack);
    end

    // hold the formatted write stable for the whole transaction and pulse done after ack
    always_ff @(posedge clk or negedge reset)
        if (!reset) begin
            bus.addr  <= '0;
            bus.wdata <= '0;
            bus.be    <= '0;
            st_done   <= 1'b0;
        end else begin
            st_done <= state == BUSY && bus.ack;
            if (accept) begin
                bus.addr  <= {st_addr[31:2], 2'b00};
                bus.wdata <= data_nx;
                bus.be    <= be_nx;
            end
        end
endmodule

// File: tb/tb_m_store_unit.sv
// tb_m_store_unit: randomized scoreboard bench for the M-stage store unit
module tb_m_store_unit;
    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
    } txn_t;

    logic        clk = 0;
    logic        reset;
    logic        st_valid, st_ov, st_flush;
    logic [1:0]  st_sel;
    logic [31:0] st_addr, st_wdata;
    logic        st_exades, st_stall, st_done;
    int          tests = 0;
    int          fails = 0;
    txn_t        exp_q[$];
    txn_t        cur;
    logic        prev_req = 0;
    logic        prev_fire = 0;

    m_store_unit_if bus_if();

    m_store_unit dut (
        .clk(clk), .reset(reset), .st_valid(st_valid), .st_sel(st_sel),
        .st_addr(st_addr), .st_wdata(st_wdata), .st_ov(st_ov), .st_flush(st_flush),
        .st_exades(st_exades), .st_stall(st_stall), .st_done(st_done), .bus(bus_if)
    );

    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [67:0] act, input logic [67:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic logic model_fault(input logic [1:0] sel, input logic [31:0] a, input logic ov);
        logic tmr, reg8, inrange, mis;
        tmr     = (a >= 32'h7F00 && a <= 32'h7F0B) || (a >= 32'h7F10 && a <= 32'h7F1B);
        reg8    = (a >= 32'h7F08 && a <= 32'h7F0B) || (a >= 32'h7F18 && a <= 32'h7F1B);
        inrange = a <= 32'h2FFF || tmr;
        mis     = (a % (32'd4 >> sel)) != 0;
        return ov || mis || !inrange || (tmr && sel != 2'd0) || reg8;
    endfunction

    function automatic txn_t model_txn(input logic [1:0] sel, input logic [31:0] a, input logic [31:0] w);
        txn_t t;
        int   src;
        t.addr = a & ~32'd3;
        t.be   = '0;
        t.data = '0;
        for (int i = 0; i < 4; i++) begin
            src = sel == 2'd0 ? i : sel == 2'd1 ? i % 2 : 0;
            t.data[8*i +: 8] = w[8*src +: 8];
            if (sel == 2'd0 || (sel == 2'd1 && i / 2 == int'(a[1])) || (sel == 2'd2 && i == int'(a[1:0])))
                t.be[i] = 1'b1;
        end
        return t;
    endfunction

    task automatic junk();
        st_valid = 1'($urandom);
        st_flush = 1'($urandom);
        st_sel   = 2'($urandom);
        st_addr  = $urandom;
        st_wdata = $urandom;
        st_ov    = 1'($urandom);
    endtask

    task automatic do_store(input logic v, input logic [1:0] sel, input logic [31:0] a, input logic [31:0] w,
                            input logic ov, input logic fl, input int d);
        logic f, acc;
        @(posedge clk); #1;
        st_valid = v; st_sel = sel; st_addr = a; st_wdata = w; st_ov = ov; st_flush = fl;
        bus_if.ack = 1'($urandom);
        f   = model_fault(sel, a, ov);
        acc = v && sel != 2'd3 && !f && !fl;
        @(negedge clk);
        check("exades", st_exades, v && sel != 2'd3 && f);
        check("stall_issue", st_stall, acc);
        if (acc) exp_q.push_back(model_txn(sel, a, w));
        @(posedge clk); #1;
        bus_if.ack = 0;
        if (acc) begin
            junk();
            for (int i = 0; i < d; i++) begin
                @(negedge clk);
                check("stall_busy", st_stall, 1);
                check("exades_busy", st_exades, 0);
                @(posedge clk); #1;
                junk();
            end
            bus_if.ack = 1;
            @(negedge clk);
            check("stall_ack", st_stall, 0);
            @(posedge clk); #1;
            bus_if.ack = 0;
        end else begin
            st_valid = 0;
            @(negedge clk);
            check("no_req", bus_if.req, 0);
            check("no_stall", st_stall, 0);
        end
        st_valid = 0;
        st_flush = 0;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            prev_req  = 0;
            prev_fire = 0;
        end else begin
            check("done", st_done, prev_fire);
            if (bus_if.req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("bus_addr", bus_if.addr, cur.addr);
                    check("bus_wdata", bus_if.wdata, cur.data);
                    check("bus_be", bus_if.be, cur.be);
                end
            end else if (bus_if.req) begin
                check("bus_stable", {bus_if.addr, bus_if.wdata, bus_if.be}, {cur.addr, cur.data, cur.be});
            end
            prev_req  = bus_if.req;
            prev_fire = bus_if.req & bus_if.ack;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 0; st_valid = 0; st_sel = 2'd3; st_addr = 0; st_wdata = 0; st_ov = 0; st_flush = 0;
        bus_if.ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_req", bus_if.req, 0);
        check("rst_bus", {bus_if.addr, bus_if.wdata, bus_if.be}, 0);
        check("rst_done", st_done, 0);
        reset = 1;
        do_store(1, 2'd0, 32'h0000_1004, 32'hDEADBEEF, 0, 0, 0);
        do_store(1, 2'd2, 32'h0000_0003, 32'h12345678, 0, 0, 1);
        do_store(1, 2'd1, 32'h0000_0002, 32'hABCD1234, 0, 0, 2);
        do_store(1, 2'd1, 32'h0000_0001, 32'h1111_2222, 0, 0, 0);
        do_store(1, 2'd0, 32'h0000_3000, 32'h3333_4444, 0, 0, 0);
        do_store(1, 2'd2, 32'h0000_7F04, 32'h5555_6666, 0, 0, 0);
        do_store(1, 2'd0, 32'h0000_7F08, 32'h7777_8888, 0, 0, 0);
        do_store(1, 2'd0, 32'h0000_0100, 32'h9999_AAAA, 1, 0, 0);
        do_store(1, 2'd0, 32'h0000_7F10, 32'hCAFE_F00D, 0, 0, 4);
        do_store(1, 2'd0, 32'h0000_0104, 32'hBBBB_CCCC, 0, 1, 0);
        do_store(1, 2'd3, 32'h0000_0108, 32'hDDDD_EEEE, 0, 0, 0);
        do_store(0, 2'd0, 32'h0000_010C, 32'h0123_4567, 0, 0, 0);
        @(posedge clk); #1;
        st_valid = 1; st_sel = 2'd0; st_addr = 32'h200; st_wdata = 32'h2468_ACE0; st_ov = 0; st_flush = 0;
        @(negedge clk);
        check("stall_pre_rst", st_stall, 1);
        exp_q.push_back(model_txn(2'd0, 32'h200, 32'h2468_ACE0));
        @(posedge clk); #1;
        st_valid = 0;
        @(negedge clk); #2;
        reset = 0;
        #1;
        check("rst_async_req", bus_if.req, 0);
        check("rst_async_bus", {bus_if.addr, bus_if.wdata, bus_if.be}, 0);
        check("rst_async_stall", st_stall, 0);
        @(posedge clk); #1;
        reset = 1;
        do_store(1, 2'd2, 32'h0000_0205, 32'h0000_00A5, 0, 0, 1);
        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            case ($urandom_range(0, 4))
                0: a = $urandom_range(0, 32'h2FFF);
                1: a = 32'h7F00 + $urandom_range(0, 15);
                2: a = 32'h7F10 + $urandom_range(0, 15);
                3: a = $urandom;
                default: a = 32'h2FF0 + $urandom_range(0, 31);
            endcase
            do_store($urandom_range(0, 7) != 0, 2'($urandom_range(0, 3)), a, $urandom,
                     $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4));
        end
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
